// File: rtl/issue_queue_param.sv
// issue_queue_param
// Parametrised out-of-order issue queue. Entries sit in an age-ordered shift queue (slot 0 is the
// oldest, slot i is valid when i < count). Each entry holds two source operands that are woken
// and captured from N_BCAST result broadcasts and, optionally, by the tag of the entry being
// issued this cycle. The oldest eligible entry moves into a registered issue slot with
// valid/ready backpressure; younger entries compact down in the same cycle.
//
// Ports:
//   clk, rst_aH (async, active high), flush (sync, drops everything incl. same-cycle dispatch)
//   disp_*  : dispatch request, two sources (valid/ready/tag/data), dst flag, tag, payload
//   bc_*    : N_BCAST broadcast channels (valid/tag/data), channel 0 has highest priority
//   iss_*   : registered issue slot (valid/ready handshake, tag, operands, payload)
//   count   : number of occupied entries
module issue_queue_param #(
  parameter int unsigned N_ENTRIES     = 8,
  parameter int unsigned N_BCAST       = 2,
  parameter int unsigned ROB_ID_WIDTH  = 6,
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned PAYLOAD_WIDTH = 64,
  parameter int unsigned SELF_WAKEUP   = 1
) (
  input  logic                              clk,
  input  logic                              rst_aH,
  input  logic                              flush,
  input  logic                              disp_valid,
  output logic                              disp_ready,
  input  logic [1:0]                        disp_src_valid,
  input  logic [1:0]                        disp_src_ready,
  input  logic [2*ROB_ID_WIDTH-1:0]         disp_src_rob_id,
  input  logic [2*DATA_WIDTH-1:0]           disp_src_data,
  input  logic                              disp_dst_valid,
  input  logic [ROB_ID_WIDTH-1:0]           disp_rob_id,
  input  logic [PAYLOAD_WIDTH-1:0]          disp_payload,
  input  logic [N_BCAST-1:0]                bc_valid,
  input  logic [N_BCAST*ROB_ID_WIDTH-1:0]   bc_rob_id,
  input  logic [N_BCAST*DATA_WIDTH-1:0]     bc_data,
  output logic                              iss_valid,
  input  logic                              iss_ready,
  output logic [ROB_ID_WIDTH-1:0]           iss_rob_id,
  output logic [2*DATA_WIDTH-1:0]           iss_src_data,
  output logic [PAYLOAD_WIDTH-1:0]          iss_payload,
  output logic [$clog2(N_ENTRIES):0]        count
);

  localparam int unsigned CW = $clog2(N_ENTRIES) + 1;
  localparam int unsigned IW = $clog2(N_ENTRIES);

  typedef struct packed {
    logic [1:0]                   src_valid;
    logic [1:0]                   src_ready;
    logic [1:0][ROB_ID_WIDTH-1:0] src_tag;
    logic [1:0][DATA_WIDTH-1:0]   src_data;
    logic                         dst_valid;
    logic [ROB_ID_WIDTH-1:0]      rob_id;
    logic [PAYLOAD_WIDTH-1:0]     payload;
  } entry_t;

  // Broadcast capture (lowest channel wins, also refreshes already-ready sources so that
  // self-woken sources pick up their data) plus self wakeup (ready bit only, no data).
  function automatic entry_t f_capture(input entry_t                          e,
                                       input logic [N_BCAST-1:0]              v,
                                       input logic [N_BCAST*ROB_ID_WIDTH-1:0] t,
                                       input logic [N_BCAST*DATA_WIDTH-1:0]   d,
                                       input logic                            sw_v,
                                       input logic [ROB_ID_WIDTH-1:0]         sw_t);
    entry_t r;
    logic   hit;
    r = e;
    for (int s = 0; s < 2; s++) begin
      hit = 1'b0;
      for (int c = 0; c < N_BCAST; c++) begin
        if (!hit && e.src_valid[s] && v[c] &&
            (t[c*ROB_ID_WIDTH +: ROB_ID_WIDTH] == e.src_tag[s])) begin
          hit            = 1'b1;
          r.src_ready[s] = 1'b1;
          r.src_data[s]  = d[c*DATA_WIDTH +: DATA_WIDTH];
        end
      end
      if (sw_v && e.src_valid[s] && !e.src_ready[s] && (e.src_tag[s] == sw_t)) begin
        r.src_ready[s] = 1'b1;
      end
    end
    return r;
  endfunction

  entry_t                     r_q     [N_ENTRIES];
  entry_t                     w_upd   [N_ENTRIES];
  entry_t                     w_q_d   [N_ENTRIES];
  entry_t                     w_disp_raw;
  entry_t                     w_disp;
  logic [CW-1:0]              r_count;
  logic [CW-1:0]              w_count_d;
  logic [CW-1:0]              w_wr_idx;
  logic [N_ENTRIES-1:0]       w_elig;
  logic                       w_any;
  logic [IW-1:0]              w_sel;
  logic                       w_adv;
  logic                       w_deq;
  logic                       w_acc;
  logic                       w_sw_valid;
  logic [ROB_ID_WIDTH-1:0]    w_sw_tag;

  logic                       r_iss_valid;
  logic [ROB_ID_WIDTH-1:0]    r_iss_rob_id;
  logic [1:0][DATA_WIDTH-1:0] r_iss_data;
  logic [PAYLOAD_WIDTH-1:0]   r_iss_payload;

  assign disp_ready   = (r_count < CW'(N_ENTRIES));
  assign count        = r_count;
  assign iss_valid    = r_iss_valid;
  assign iss_rob_id   = r_iss_rob_id;
  assign iss_src_data = r_iss_data;
  assign iss_payload  = r_iss_payload;

  assign w_adv = ~r_iss_valid | iss_ready;
  assign w_deq = w_adv & w_any;
  assign w_acc = disp_valid & disp_ready;

  // Eligibility and oldest-first selection.
  always_comb begin
    w_elig = '0;
    w_any  = 1'b0;
    w_sel  = '0;
    for (int unsigned i = 0; i < N_ENTRIES; i++) begin
      w_elig[i] = (CW'(i) < r_count) && ((~r_q[i].src_valid | r_q[i].src_ready) == 2'b11);
    end
    for (int unsigned i = 0; i < N_ENTRIES; i++) begin
      if (!w_any && w_elig[i]) begin
        w_any = 1'b1;
        w_sel = IW'(i);
      end
    end
  end

  assign w_sw_valid = (SELF_WAKEUP != 0) && w_deq && r_q[w_sel].dst_valid;
  assign w_sw_tag   = r_q[w_sel].rob_id;

  always_comb begin
    w_disp_raw.src_valid = disp_src_valid;
    w_disp_raw.src_ready = disp_src_ready;
    w_disp_raw.src_tag   = disp_src_rob_id;
    w_disp_raw.src_data  = disp_src_data;
    w_disp_raw.dst_valid = disp_dst_valid;
    w_disp_raw.rob_id    = disp_rob_id;
    w_disp_raw.payload   = disp_payload;
  end

  assign w_disp = f_capture(w_disp_raw, bc_valid, bc_rob_id, bc_data, w_sw_valid, w_sw_tag);

  // Captured view of every slot; the selected slot's operands double as the issue bypass.
  always_comb begin
    for (int unsigned i = 0; i < N_ENTRIES; i++) begin
      w_upd[i] = f_capture(r_q[i], bc_valid, bc_rob_id, bc_data, w_sw_valid, w_sw_tag);
    end
  end

  assign w_wr_idx = w_deq ? (r_count - CW'(1)) : r_count;

  // Compaction on dequeue, then the dispatch write at the (post-compaction) tail.
  always_comb begin
    for (int unsigned j = 0; j < N_ENTRIES; j++) begin
      w_q_d[j] = w_upd[j];
    end
    if (w_deq) begin
      for (int unsigned j = 0; j < N_ENTRIES - 1; j++) begin
        if (IW'(j) >= w_sel) begin
          w_q_d[j] = w_upd[j+1];
        end
      end
    end
    if (w_acc) begin
      for (int unsigned j = 0; j < N_ENTRIES; j++) begin
        if (CW'(j) == w_wr_idx) begin
          w_q_d[j] = w_disp;
        end
      end
    end
  end

  always_comb begin
    w_count_d = r_count;
    unique case ({w_acc, w_deq})
      2'b10:   w_count_d = r_count + CW'(1);
      2'b01:   w_count_d = r_count - CW'(1);
      default: w_count_d = r_count;
    endcase
  end

  // Entry storage; contents past count are don't-care, so flush only needs to clear count.
  always_ff @(posedge clk or posedge rst_aH) begin
    if (rst_aH) begin
      for (int unsigned i = 0; i < N_ENTRIES; i++) begin
        r_q[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < N_ENTRIES; i++) begin
        r_q[i] <= w_q_d[i];
      end
    end
  end

  always_ff @(posedge clk or posedge rst_aH) begin
    if (rst_aH) begin
      r_count       <= '0;
      r_iss_valid   <= 1'b0;
      r_iss_rob_id  <= '0;
      r_iss_data    <= '0;
      r_iss_payload <= '0;
    end else if (flush) begin
      r_count     <= '0;
      r_iss_valid <= 1'b0;
    end else begin
      r_count <= w_count_d;
      if (w_adv) begin
        r_iss_valid <= w_any;
        if (w_any) begin
          r_iss_rob_id  <= r_q[w_sel].rob_id;
          r_iss_data    <= w_upd[w_sel].src_data;
          r_iss_payload <= r_q[w_sel].payload;
        end
      end
    end
  end

endmodule

// File: tb/tb_issue_queue_param.sv
// Self-checking bench for issue_queue_param: directed scenarios plus randomized traffic, all
// checked against a queue-based reference model; issued instructions go through a scoreboard.
module tb_issue_queue_param;

  localparam int N  = 8;
  localparam int NB = 2;
  localparam int RW = 6;
  localparam int DW = 32;
  localparam int PW = 64;
  localparam bit SW = 1'b1;

  logic              clk = 1'b0;
  logic              rst_aH;
  logic              flush;
  logic              disp_valid;
  logic              disp_ready;
  logic [1:0]        disp_src_valid;
  logic [1:0]        disp_src_ready;
  logic [2*RW-1:0]   disp_src_rob_id;
  logic [2*DW-1:0]   disp_src_data;
  logic              disp_dst_valid;
  logic [RW-1:0]     disp_rob_id;
  logic [PW-1:0]     disp_payload;
  logic [NB-1:0]     bc_valid;
  logic [NB*RW-1:0]  bc_rob_id;
  logic [NB*DW-1:0]  bc_data;
  logic              iss_valid;
  logic              iss_ready;
  logic [RW-1:0]     iss_rob_id;
  logic [2*DW-1:0]   iss_src_data;
  logic [PW-1:0]     iss_payload;
  logic [$clog2(N):0] count;

  issue_queue_param #(
    .N_ENTRIES(N), .N_BCAST(NB), .ROB_ID_WIDTH(RW), .DATA_WIDTH(DW), .PAYLOAD_WIDTH(PW),
    .SELF_WAKEUP(1)
  ) u_dut (
    .clk(clk), .rst_aH(rst_aH), .flush(flush),
    .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_src_valid(disp_src_valid),
    .disp_src_ready(disp_src_ready), .disp_src_rob_id(disp_src_rob_id),
    .disp_src_data(disp_src_data), .disp_dst_valid(disp_dst_valid), .disp_rob_id(disp_rob_id),
    .disp_payload(disp_payload), .bc_valid(bc_valid), .bc_rob_id(bc_rob_id), .bc_data(bc_data),
    .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_rob_id(iss_rob_id),
    .iss_src_data(iss_src_data), .iss_payload(iss_payload), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]         sv;
    logic [1:0]         sr;
    logic [1:0][RW-1:0] tag;
    logic [1:0][DW-1:0] data;
    logic               dv;
    logic [RW-1:0]      id;
    logic [PW-1:0]      pl;
  } ment_t;

  typedef struct packed {
    logic [RW-1:0]   id;
    logic [2*DW-1:0] data;
    logic [PW-1:0]   pl;
  } exp_t;

  ment_t mq[$];
  bit    m_iv;
  ment_t m_iss;
  exp_t  sb[$];
  exp_t  mon_e;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // First broadcast channel currently carrying this tag.
  function automatic bit bc_lookup(input logic [RW-1:0] tag, output logic [DW-1:0] d);
    d = '0;
    for (int c = 0; c < NB; c++) begin
      if (bc_valid[c] && bc_rob_id[c*RW +: RW] == tag) begin
        d = bc_data[c*DW +: DW];
        return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  function automatic ment_t wake(input ment_t e, input bit sw, input logic [RW-1:0] swt);
    logic [DW-1:0] d;
    for (int s = 0; s < 2; s++) begin
      if (e.sv[s]) begin
        if (bc_lookup(e.tag[s], d)) begin
          e.sr[s]   = 1'b1;
          e.data[s] = d;
        end
        if (sw && e.tag[s] == swt) e.sr[s] = 1'b1;
      end
    end
    return e;
  endfunction

  // One clock of the reference model, using the inputs currently driven.
  task automatic model_step();
    bit            adv, deq, acc, swk;
    int            idx, sz;
    ment_t         sel, ne;
    logic [RW-1:0] swt;
    logic [DW-1:0] d;
    sz  = mq.size();
    adv = !m_iv || iss_ready;
    idx = -1;
    for (int i = 0; i < sz; i++) begin
      if (idx < 0 && ((~mq[i].sv | mq[i].sr) == 2'b11)) idx = i;
    end
    if (m_iv && iss_ready) sb.push_back('{id: m_iss.id, data: m_iss.data, pl: m_iss.pl});
    deq = adv && (idx >= 0);
    acc = disp_valid && (sz < N);
    swk = 1'b0;
    swt = '0;
    sel = '0;
    if (deq) begin
      sel = mq[idx];
      for (int s = 0; s < 2; s++) begin
        if (sel.sv[s] && bc_lookup(sel.tag[s], d)) sel.data[s] = d;
      end
      swk = SW && sel.dv;
      swt = sel.id;
      mq.delete(idx);
    end
    foreach (mq[i]) mq[i] = wake(mq[i], swk, swt);
    if (acc) begin
      ne.sv   = disp_src_valid;
      ne.sr   = disp_src_ready;
      ne.tag  = disp_src_rob_id;
      ne.data = disp_src_data;
      ne.dv   = disp_dst_valid;
      ne.id   = disp_rob_id;
      ne.pl   = disp_payload;
      mq.push_back(wake(ne, swk, swt));
    end
    if (flush) begin
      mq.delete();
      m_iv = 1'b0;
    end else if (adv) begin
      m_iv = deq;
      if (deq) m_iss = sel;
    end
  endtask

  task automatic tick();
    chk("count", count, mq.size());
    chk("disp_ready", disp_ready, mq.size() < N);
    chk("iss_valid", iss_valid, m_iv);
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    flush      = 1'b0;
    disp_valid = 1'b0;
    bc_valid   = '0;
  endtask

  task automatic set_disp(input logic [RW-1:0] id, input logic [1:0] sv, input logic [1:0] sr,
                          input logic [RW-1:0] t0, input logic [RW-1:0] t1,
                          input logic [DW-1:0] d0, input logic [DW-1:0] d1, input logic dv,
                          input logic [PW-1:0] pl);
    disp_valid      = 1'b1;
    disp_rob_id     = id;
    disp_src_valid  = sv;
    disp_src_ready  = sr;
    disp_src_rob_id = {t1, t0};
    disp_src_data   = {d1, d0};
    disp_dst_valid  = dv;
    disp_payload    = pl;
  endtask

  task automatic rand_inputs();
    flush          = ($urandom_range(0, 49) == 0);
    disp_valid     = ($urandom_range(0, 99) < 60);
    disp_src_valid = 2'($urandom);
    disp_src_ready = 2'($urandom);
    for (int s = 0; s < 2; s++) disp_src_rob_id[s*RW +: RW] = RW'($urandom_range(0, 15));
    disp_src_data  = {$urandom, $urandom};
    disp_dst_valid = 1'($urandom);
    disp_rob_id    = RW'($urandom_range(0, 15));
    disp_payload   = {$urandom, $urandom};
    for (int c = 0; c < NB; c++) begin
      bc_valid[c]          = ($urandom_range(0, 99) < 40);
      bc_rob_id[c*RW +: RW] = RW'($urandom_range(0, 15));
      bc_data[c*DW +: DW]   = $urandom;
    end
    iss_ready = ($urandom_range(0, 99) < 70);
  endtask

  always @(negedge clk) begin
    if (!rst_aH && iss_valid && iss_ready) begin
      if (sb.size() == 0) begin
        n_checks++;
        $display("FAIL issue_unexpected: tag %0h issued, nothing expected", iss_rob_id);
      end else begin
        mon_e = sb.pop_front();
        chk("iss_rob_id", iss_rob_id, mon_e.id);
        chk("iss_src_data", iss_src_data, mon_e.data);
        chk("iss_payload", iss_payload, mon_e.pl);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_aH          = 1'b1;
    iss_ready       = 1'b0;
    disp_src_valid  = '0;
    disp_src_ready  = '0;
    disp_src_rob_id = '0;
    disp_src_data   = '0;
    disp_dst_valid  = 1'b0;
    disp_rob_id     = '0;
    disp_payload    = '0;
    bc_rob_id       = '0;
    bc_data         = '0;
    idle();
    m_iv = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_count", count, 0);
    chk("rst_iss_valid", iss_valid, 0);
    chk("rst_disp_ready", disp_ready, 1);
    chk("rst_iss_data", {iss_rob_id, iss_src_data, iss_payload}, 0);
    rst_aH = 1'b0;

    // Independent ops.
    iss_ready = 1'b1;
    set_disp(3, 2'b11, 2'b11, 0, 0, 32'hA, 32'hB, 1'b0, 64'h3);
    tick();
    set_disp(4, 2'b11, 2'b11, 0, 0, 32'hC, 32'hD, 1'b0, 64'h4);
    tick();
    chk("s1_first_tag", iss_rob_id, 3);
    idle();
    tick();
    chk("s1_second_tag", iss_rob_id, 4);
    tick();
    chk("s1_count_empty", count, 0);

    // Wakeup via broadcast channel 1.
    set_disp(10, 2'b01, 2'b00, 5, 0, 32'h0, 32'h0, 1'b0, 64'h10);
    tick();
    idle();
    bc_valid  = 2'b10;
    bc_rob_id = {6'd5, 6'd63};
    bc_data   = {32'hDEAD, 32'h0};
    tick();
    idle();
    tick();
    chk("s2_tag", iss_rob_id, 10);
    chk("s2_data", iss_src_data[DW-1:0], 32'hDEAD);
    tick();

    // Self wakeup chain with bypass on channel 0.
    set_disp(7, 2'b11, 2'b11, 0, 0, 32'h1, 32'h2, 1'b1, 64'h7);
    tick();
    set_disp(8, 2'b10, 2'b00, 0, 7, 32'h3, 32'h0, 1'b0, 64'h8);
    tick();
    idle();
    bc_valid  = 2'b01;
    bc_rob_id = {6'd0, 6'd7};
    bc_data   = {32'h0, 32'h42};
    tick();
    idle();
    chk("s3_tag", iss_rob_id, 8);
    chk("s3_bypass", iss_src_data[2*DW-1:DW], 32'h42);
    tick();

    // Backpressure and full.
    iss_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      set_disp(RW'(20 + i), 2'b11, 2'b11, 0, 0, 32'(i), 32'(i + 100), 1'b0, 64'(i));
      tick();
    end
    idle();
    chk("s4_disp_ready", disp_ready, 0);
    chk("s4_count", count, 8);
    chk("s4_hold_tag", iss_rob_id, 20);
    iss_ready = 1'b1;
    repeat (10) tick();
    chk("s4_drained", count, 0);

    // Flush while full, issue slot occupied, concurrent dispatch.
    iss_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      set_disp(RW'(40 + i), 2'b11, 2'b11, 0, 0, 32'(i), 32'(i), 1'b0, 64'(i));
      tick();
    end
    flush = 1'b1;
    set_disp(50, 2'b11, 2'b11, 0, 0, 32'h5, 32'h5, 1'b0, 64'h50);
    tick();
    idle();
    chk("s5_count", count, 0);
    chk("s5_iss_valid", iss_valid, 0);
    tick();
    chk("s5_dropped", count, 0);

    // Same tag on both channels: channel 0 wins.
    iss_ready = 1'b1;
    set_disp(30, 2'b01, 2'b00, 12, 0, 32'h0, 32'h0, 1'b0, 64'h30);
    tick();
    idle();
    bc_valid  = 2'b11;
    bc_rob_id = {6'd12, 6'd12};
    bc_data   = {32'h2222, 32'h1111};
    tick();
    idle();
    tick();
    chk("s6_tag", iss_rob_id, 30);
    chk("s6_data", iss_src_data[DW-1:0], 32'h1111);
    tick();

    // Randomized traffic.
    repeat (2000) begin
      rand_inputs();
      tick();
    end
    chk("sb_drained", sb.size(), 0);

    // Asynchronous reset mid-operation.
    rand_inputs();
    flush = 1'b0;
    disp_valid = 1'b1;
    tick();
    rst_aH = 1'b1;
    #1;
    chk("arst_count", count, 0);
    chk("arst_iss_valid", iss_valid, 0);
    chk("arst_disp_ready", disp_ready, 1);
    chk("arst_iss_data", {iss_rob_id, iss_src_data, iss_payload}, 0);
    mq.delete();
    sb.delete();
    m_iv = 1'b0;
    idle();
    @(posedge clk);
    #1;
    rst_aH = 1'b0;
    tick();
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
